// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcode map (kept in
// step with the decoder), mnemonic codes, error codes, field positions and
// the loader FSM state encoding.
package instr_encoder_loader_pkg;

    // Symbolic mnemonic codes carried on In_Op; codes 11..15 are undefined.
    typedef enum logic [3:0] {
        MN_ALU  = 4'd0,
        MN_LI   = 4'd1,
        MN_ADDI = 4'd2,
        MN_ANDI = 4'd3,
        MN_ORI  = 4'd4,
        MN_LW   = 4'd5,
        MN_LB   = 4'd6,
        MN_SW   = 4'd7,
        MN_B    = 4'd8,
        MN_BEQ  = 4'd9,
        MN_BNE  = 4'd10
    } mnemonic_e;

    // 6-bit primary opcodes, identical to the decoder's table.
    localparam logic [5:0] OPC_ALU  = 6'b100000;
    localparam logic [5:0] OPC_ADDI = 6'b110000;
    localparam logic [5:0] OPC_ANDI = 6'b110010;
    localparam logic [5:0] OPC_ORI  = 6'b110011;
    localparam logic [5:0] OPC_LW   = 6'b001111;
    localparam logic [5:0] OPC_LB   = 6'b000011;
    localparam logic [5:0] OPC_SW   = 6'b011111;
    localparam logic [5:0] OPC_BEQ  = 6'b000000;
    localparam logic [5:0] OPC_BNE  = 6'b000001;
    localparam logic [5:0] OPC_LI   = 6'b111000;
    localparam logic [5:0] OPC_B    = 6'b111111;

    // Error codes reported on Err_Code.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_OP   = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    // Least-significant bit of each instruction field.
    localparam int OPC_LSB  = 26;
    localparam int RS_LSB   = 21;
    localparam int RD_LSB   = 16;
    localparam int RT_LSB   = 11;
    localparam int IMM_LSB  = 0;
    localparam int FUNC_LSB = 0;

    // Loader FSM states; exported on Dbg_State.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_encode.sv
// Pure combinational encoder: descriptor fields -> 32-bit instruction word,
// plus a flag for mnemonic codes that have no encoding.
module instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rd,
    input  logic [4:0]  rt,
    input  logic [15:0] imm,
    input  logic [3:0]  func,
    output logic [31:0] word,
    output logic        bad_op
);

    // Assemble the word field by field; unused bits stay zero.
    always_comb begin
        word   = '0;
        bad_op = 1'b0;
        case (op)
            MN_ALU: begin
                word[OPC_LSB +: 6]  = OPC_ALU;
                word[RS_LSB +: 5]   = rs;
                word[RD_LSB +: 5]   = rd;
                word[RT_LSB +: 5]   = rt;
                word[FUNC_LSB +: 4] = func;
            end
            MN_ADDI, MN_ANDI, MN_ORI, MN_LW, MN_LB, MN_SW, MN_BEQ, MN_BNE: begin
                case (op)
                    MN_ADDI: word[OPC_LSB +: 6] = OPC_ADDI;
                    MN_ANDI: word[OPC_LSB +: 6] = OPC_ANDI;
                    MN_ORI:  word[OPC_LSB +: 6] = OPC_ORI;
                    MN_LW:   word[OPC_LSB +: 6] = OPC_LW;
                    MN_LB:   word[OPC_LSB +: 6] = OPC_LB;
                    MN_SW:   word[OPC_LSB +: 6] = OPC_SW;
                    MN_BEQ:  word[OPC_LSB +: 6] = OPC_BEQ;
                    default: word[OPC_LSB +: 6] = OPC_BNE;
                endcase
                word[RS_LSB +: 5]   = rs;
                word[RD_LSB +: 5]   = rd;
                word[IMM_LSB +: 16] = imm;
            end
            MN_LI: begin
                // rs is architecturally zero for load-immediate
                word[OPC_LSB +: 6]  = OPC_LI;
                word[RD_LSB +: 5]   = rd;
                word[IMM_LSB +: 16] = imm;
            end
            MN_B: begin
                // unconditional branch: both register fields zero
                word[OPC_LSB +: 6]  = OPC_B;
                word[IMM_LSB +: 16] = imm;
            end
            default: bad_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction descriptors, encodes them, writes each
// word to instruction memory and reads it back to verify before moving on.
//
// Handshake: a descriptor transfers on a rising edge where In_Valid and
// In_Ready are both high; In_Ready is high only in ACCEPT and does not depend
// on In_Valid, and In_Valid is ignored whenever In_Ready is low.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_Addr,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [3:0]        In_Op,
    input  logic [4:0]        In_Rs,
    input  logic [4:0]        In_Rd,
    input  logic [4:0]        In_Rt,
    input  logic [15:0]       In_Imm,
    input  logic [3:0]        In_Func,
    input  logic              In_Last,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_WrData,
    output logic              Mem_WrEn,
    input  logic [31:0]       Mem_RdData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [1:0]        Err_Code,
    output logic [ADDR_W:0]   Word_Count,
    output logic [2:0]        Dbg_State
);

    localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_bad;
    logic [ADDR_W:0]   count_inc;

    instr_encode u_encode (
        .op     (In_Op),
        .rs     (In_Rs),
        .rd     (In_Rd),
        .rt     (In_Rt),
        .imm    (In_Imm),
        .func   (In_Func),
        .word   (enc_word),
        .bad_op (enc_bad)
    );

    assign count_inc = count_q + CNT_ONE;

    // Next-state, address counter, word latch and readback compare.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    addr_d  = Start_Addr;
                    count_d = '0;
                    err_d   = ERR_NONE;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (In_Valid) begin
                    if (enc_bad) begin
                        err_d   = ERR_BAD_OP;
                        state_d = ST_ERR;
                    end else begin
                        word_d  = enc_word;
                        last_d  = In_Last;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: state_d = ST_READ;
            ST_READ:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (Mem_RdData != word_q) begin
                    err_d   = ERR_MISMATCH;
                    state_d = ST_ERR;
                end else begin
                    count_d = count_inc;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (count_inc == MAX_CNT || addr_q == '1) begin
                        // capacity or end of memory reached: stop, never wrap
                        err_d   = ERR_OVERFLOW;
                        state_d = ST_ERR;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    always_comb begin
        In_Ready   = (state_q == ST_ACCEPT);
        Mem_WrEn   = (state_q == ST_WRITE);
        Busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE) ||
                     (state_q == ST_READ)   || (state_q == ST_CHECK);
        Done       = (state_q == ST_DONE);
        Error      = (state_q == ST_ERR);
        Err_Code   = err_q;
        Word_Count = count_q;
        Mem_Addr   = addr_q;
        Mem_WrData = word_q;
        Dbg_State  = state_q;
    end

endmodule
